// File: rtl/spi_flash_reader.sv
`timescale 1ns/1ps
// spi_flash_reader
// Fetches one little-endian 32-bit word from a serial SPI flash (mode 0) per
// read strobe. Each transfer is: chip select low, the read opcode plus the
// word-aligned byte address shifted out MSB first, 32 data bits shifted in,
// chip select high. Each SPI bit takes two clk cycles (SCLK low, then high).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   mem_addr   byte address from the core (bits [1:0] ignored)
//   mem_rstrb  one-cycle read request, accepted only while idle
//   mem_rdata  last fetched word; byte k in arrival order lands in [8k+7:8k]
//   mem_rbusy  high while a transfer is in progress
//   spi_cs_n   flash chip select, active low
//   spi_clk    SPI clock, idle low
//   spi_mosi   serial data to the flash, MSB first
//   spi_miso   serial data from the flash
module spi_flash_reader #(
  parameter int unsigned ADDR_BITS = 24,
  parameter logic [7:0]  READ_CMD  = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_rstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_rbusy,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int unsigned SEND_BITS = 8 + ADDR_BITS;
  localparam logic [5:0]  SEND_LAST = 6'(SEND_BITS - 1);
  localparam logic [5:0]  RECV_LAST = 6'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } stateType;

  stateType             state;
  logic                 phase;      // 0: SCLK low half of a bit, 1: SCLK high half
  logic [5:0]           bitCount;
  logic [SEND_BITS-2:0] txShift;    // bits still to send after the one on spi_mosi
  logic [30:0]          rxShift;    // data bits received so far, first bit oldest
  logic [31:0]          rxNext;
  logic [SEND_BITS-1:0] txLoad;
  logic                 unusedAddrBits;

  // Outgoing frame: opcode followed by the word-aligned address.
  assign txLoad = {READ_CMD, mem_addr[ADDR_BITS-1:2], 2'b00};

  // Low address bits select a byte within the word and play no part here.
  assign unusedAddrBits = ^mem_addr[1:0];

  // Receive window including the bit sampled on the current edge.
  assign rxNext = {rxShift, spi_miso};

  assign mem_rbusy = (state != IDLE);

  // Transfer sequencer: opcode/address shift-out, data shift-in, SPI pin drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      bitCount  <= 6'd0;
      txShift   <= '0;
      rxShift   <= 31'd0;
      mem_rdata <= 32'h0000_0000;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase   <= 1'b0;
          spi_clk <= 1'b0;
          if (mem_rstrb) begin
            // First bit goes straight onto MOSI so it is stable for the
            // whole low half of bit 0.
            state    <= SEND;
            bitCount <= 6'd0;
            spi_cs_n <= 1'b0;
            spi_mosi <= txLoad[SEND_BITS-1];
            txShift  <= txLoad[SEND_BITS-2:0];
          end else begin
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
          end
        end

        SEND: begin
          if (!phase) begin
            phase   <= 1'b1;
            spi_clk <= 1'b1;
          end else begin
            // MOSI only moves together with SCLK falling.
            phase   <= 1'b0;
            spi_clk <= 1'b0;
            if (bitCount == SEND_LAST) begin
              state    <= RECV;
              bitCount <= 6'd0;
              spi_mosi <= 1'b0;
            end else begin
              bitCount <= bitCount + 6'd1;
              spi_mosi <= txShift[SEND_BITS-2];
              txShift  <= {txShift[SEND_BITS-3:0], 1'b0};
            end
          end
        end

        RECV: begin
          spi_mosi <= 1'b0;
          if (!phase) begin
            phase   <= 1'b1;
            spi_clk <= 1'b1;
          end else begin
            // Sample on the edge that ends the SCLK-high half.
            phase   <= 1'b0;
            spi_clk <= 1'b0;
            rxShift <= rxNext[30:0];
            if (bitCount == RECV_LAST) begin
              // First byte received is the least significant byte.
              state     <= IDLE;
              bitCount  <= 6'd0;
              spi_cs_n  <= 1'b1;
              mem_rdata <= {rxNext[7:0], rxNext[15:8], rxNext[23:16], rxNext[31:24]};
            end else begin
              bitCount <= bitCount + 6'd1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          phase    <= 1'b0;
          bitCount <= 6'd0;
          spi_cs_n <= 1'b1;
          spi_clk  <= 1'b0;
          spi_mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
// Testbench for spi_flash_reader: randomized reads against a behavioural
// flash model, with a scoreboard of expected frames and words.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;

  spi_flash_reader #(.ADDR_BITS(24), .READ_CMD(8'h03)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Scoreboard queues filled at stimulus time.
  logic [31:0] expCmdQ[$];    // expected 32 bits on MOSI per frame
  logic [31:0] expRdataQ[$];  // expected mem_rdata per completed transfer
  logic [31:0] flashQ[$];     // serial data stream the flash returns per frame
  logic [31:0] lastRdata = 32'h0;
  bit          abortPending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- flash model ----------------
  int          edgeN = 0;
  int          bitIdx = 0;
  logic [31:0] cmdCap = 32'h0;
  logic [31:0] curStream = 32'h0;
  logic [31:0] expCmd;
  bit          mosiRecvBad = 1'b0;
  bit          frameActive = 1'b0;

  // Frame start: fetch the data this frame should return.
  always @(negedge spi_cs_n) begin
    frameActive = 1'b1;
    edgeN       = 0;
    cmdCap      = 32'h0;
    mosiRecvBad = 1'b0;
    curStream   = (flashQ.size() > 0) ? flashQ.pop_front() : 32'h0;
  end

  // Flash captures MOSI on rising SCLK.
  always @(posedge spi_clk) begin
    if (!spi_cs_n) begin
      if (edgeN < 32) cmdCap = {cmdCap[30:0], spi_mosi};
      else if (spi_mosi !== 1'b0) mosiRecvBad = 1'b1;
      edgeN++;
    end
  end

  // Flash shifts out the next data bit after falling SCLK (mode 0).
  always @(negedge spi_clk) begin
    if (!spi_cs_n && edgeN >= 32 && edgeN < 64) begin
      bitIdx = edgeN - 32;
      #1 spi_miso = curStream[31 - bitIdx];
    end
  end

  // Frame end: compare the captured command and the SCLK edge count.
  always @(posedge spi_cs_n) begin
    if (frameActive) begin
      frameActive = 1'b0;
      if (abortPending) begin
        abortPending = 1'b0;
        if (expCmdQ.size() > 0) void'(expCmdQ.pop_back());
      end else begin
        expCmd = (expCmdQ.size() > 0) ? expCmdQ.pop_front() : 32'hxxxx_xxxx;
        check("mosi_cmd", 64'(cmdCap), 64'(expCmd));
        check("sclk_edges", 64'(edgeN), 64'(64));
        check("mosi_low_in_recv", 64'(mosiRecvBad), 64'(0));
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prevBusy = 1'b0;
  logic        prevMosi = 1'b0;
  int          busyLen  = 0;
  logic [31:0] expData;

  always @(posedge clk) begin
    #1;
    check("cs_vs_busy", 64'(spi_cs_n), 64'(!mem_rbusy));
    if (spi_cs_n) check("sclk_idle_low", 64'(spi_clk), 64'(0));
    if (spi_mosi !== prevMosi) check("mosi_change_sclk_low", 64'(spi_clk), 64'(0));
    if (reset && mem_rstrb && !prevBusy) check("busy_after_strobe", 64'(mem_rbusy), 64'(1));
    if (reset && prevBusy && !mem_rbusy) begin
      expData = (expRdataQ.size() > 0) ? expRdataQ.pop_front() : 32'hxxxx_xxxx;
      check("rdata", 64'(mem_rdata), 64'(expData));
      check("busy_cycles", 64'(busyLen), 64'(128));
      lastRdata = expData;
    end else begin
      check("rdata_hold", 64'(mem_rdata), 64'(lastRdata));
    end
    busyLen  = mem_rbusy ? busyLen + 1 : 0;
    prevBusy = mem_rbusy;
    prevMosi = spi_mosi;
  end

  // ---------------- stimulus ----------------
  // Issue an accepted read; caller is at a negedge with the DUT idle.
  // b[k] is the k-th byte the flash returns.
  task automatic startRead(input logic [23:0] addr, input logic [7:0] b [4]);
    logic [31:0] word;
    logic [31:0] stream;
    for (int k = 0; k < 4; k++) begin
      word[8*k +: 8]        = b[k];
      stream[31-8*k -: 8]   = b[k];
    end
    expCmdQ.push_back({8'h03, addr & 24'hFFFFFC});
    expRdataQ.push_back(word);
    flashQ.push_back(stream);
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (mem_rbusy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(mem_rbusy), 64'(0));
  endtask

  task automatic checkResetOutputs();
    check("rst_cs_n", 64'(spi_cs_n), 64'(1));
    check("rst_sclk", 64'(spi_clk), 64'(0));
    check("rst_mosi", 64'(spi_mosi), 64'(0));
    check("rst_busy", 64'(mem_rbusy), 64'(0));
    check("rst_rdata", 64'(mem_rdata), 64'(0));
  endtask

  initial begin
    logic [7:0]  b [4];
    logic [23:0] a;
    reset     = 1'b1;
    mem_rstrb = 1'b0;
    mem_addr  = 24'h0;
    spi_miso  = 1'b0;
    #2 reset = 1'b0;
    #1 checkResetOutputs();
    repeat (3) @(negedge clk);

    // Release with a strobe on the very first edge afterwards.
    reset = 1'b1;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    startRead(24'h012346, b);
    // Strobe around cycle 50 of the transfer must be ignored.
    repeat (48) @(negedge clk);
    mem_addr  = 24'hABCDEF;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    waitIdle();

    // Back-to-back, all-ones data at the top word address.
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    startRead(24'hFFFFFC, b);
    waitIdle();

    // Random reads; a zero gap strobes in the cycle busy falls.
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      a = 24'($urandom);
      startRead(a, b);
      waitIdle();
    end

    // Reset mid-transfer aborts it.
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    a = 24'($urandom);
    startRead(a, b);
    repeat (39) @(negedge clk);
    abortPending = 1'b1;
    reset = 1'b0;
    #1 checkResetOutputs();
    if (expRdataQ.size() > 0) void'(expRdataQ.pop_back());
    lastRdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    b = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    startRead(24'h123456, b);
    waitIdle();
    repeat (4) @(negedge clk);

    check("queues_drained", 64'(expRdataQ.size() + expCmdQ.size()), 64'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
